// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a handshake to instruction memory.
//
// Fetches one instruction per cycle when memory answers with zero latency. It
// tolerates arbitrary ack latency, a pipeline stall from the hazard unit, and
// branch/jump redirects from EX/MEM. The request address is held stable from
// the request until its ack.
//
// Parameters
//   RESET_PC     first fetch address after reset
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   pcsrc        redirect request (branch/jump taken)
//   pc_branch    redirect target, valid when pcsrc=1; low two bits forced to 0
//   stall        hazard-unit freeze of PC and IF/ID
//   imem_req     instruction-memory read request
//   imem_addr    instruction-memory read address
//   imem_ack     imem_rdata valid this cycle
//   imem_rdata   fetched instruction word
//   pc_out       current fetch PC
//   if_id_pc     IF/ID register: PC of the instruction
//   if_id_pc4    IF/ID register: PC+4 (wraps modulo 2^32)
//   if_id_instr  IF/ID register: instruction word
//   if_id_valid  IF/ID holds a real instruction (0 = bubble)
//   fetch_fault  sticky misaligned-redirect flag
//
// Configuration
//   IF_STAGE_ALIGN_CHECK_EN  when defined, a redirect whose target has nonzero
//                            low bits sets fetch_fault until reset. The
//                            redirect itself still goes to the aligned target.
//                            When undefined, fetch_fault is constant 0.
// -----------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcsrc,
   input  logic [31:0] pc_branch,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        fetch_fault
);

   // REQ: request outstanding at pc. HELD: word captured during a stall,
   // waiting for the stall to clear. DRAIN: a redirect arrived while a request
   // was outstanding, so the stage waits for that ack and discards its data.
   typedef enum logic [1:0] {REQ, HELD, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifpc_q, ifpc_d;
   logic [31:0] ifpc4_q, ifpc4_d;
   logic [31:0] ifinstr_q, ifinstr_d;
   logic        ifv_q, ifv_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] redir_q, redir_d;

   logic [31:0] pc_plus4;
   logic [31:0] target;

   assign pc_plus4 = pc_q + 32'd4;
   assign target   = {pc_branch[31:2], 2'b00};

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ifpc_d    = ifpc_q;
      ifpc4_d   = ifpc4_q;
      ifinstr_d = ifinstr_q;
      ifv_d     = ifv_q;
      hold_d    = hold_q;
      redir_d   = redir_q;

      case (state_q)
         REQ: begin
            if (pcsrc) begin
               ifv_d = 1'b0;
               if (imem_ack) begin
                  pc_d = target;
               end else begin
                  // Outstanding request must complete at its original address.
                  redir_d = target;
                  state_d = DRAIN;
               end
            end else if (imem_ack) begin
               if (stall) begin
                  hold_d  = imem_rdata;
                  state_d = HELD;
               end else begin
                  ifpc_d    = pc_q;
                  ifpc4_d   = pc_plus4;
                  ifinstr_d = imem_rdata;
                  ifv_d     = 1'b1;
                  pc_d      = pc_plus4;
               end
            end else if (!stall) begin
               ifv_d = 1'b0;
            end
         end

         HELD: begin
            if (pcsrc) begin
               ifv_d   = 1'b0;
               pc_d    = target;
               state_d = REQ;
            end else if (!stall) begin
               ifpc_d    = pc_q;
               ifpc4_d   = pc_plus4;
               ifinstr_d = hold_q;
               ifv_d     = 1'b1;
               pc_d      = pc_plus4;
               state_d   = REQ;
            end
         end

         DRAIN: begin
            ifv_d = 1'b0;
            if (imem_ack) begin
               // A redirect arriving with the ack is the newest one and wins.
               pc_d    = pcsrc ? target : redir_q;
               state_d = REQ;
            end else if (pcsrc) begin
               redir_d = target;
            end
         end

         default: state_d = REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= REQ;
         pc_q      <= RESET_PC;
         ifpc_q    <= '0;
         ifpc4_q   <= '0;
         ifinstr_q <= '0;
         ifv_q     <= 1'b0;
         hold_q    <= '0;
         redir_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ifpc_q    <= ifpc_d;
         ifpc4_q   <= ifpc4_d;
         ifinstr_q <= ifinstr_d;
         ifv_q     <= ifv_d;
         hold_q    <= hold_d;
         redir_q   <= redir_d;
      end
   end

`ifdef IF_STAGE_ALIGN_CHECK_EN
   logic fault_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else if (pcsrc && (pc_branch[1:0] != 2'b00)) begin
         fault_q <= 1'b1;
      end
   end

   assign fetch_fault = fault_q;
`else
   // Low target bits are dropped silently in this build.
   logic unused_branch_lsbs;
   assign unused_branch_lsbs = ^pc_branch[1:0];
   assign fetch_fault        = 1'b0;
`endif

   assign imem_req    = !rst && (state_q != HELD);
   assign imem_addr   = pc_q;
   assign pc_out      = pc_q;
   assign if_id_pc    = ifpc_q;
   assign if_id_pc4   = ifpc4_q;
   assign if_id_instr = ifinstr_q;
   assign if_id_valid = ifv_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcsrc;
   logic [31:0] pc_branch;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        fetch_fault;

`ifdef IF_STAGE_ALIGN_CHECK_EN
   localparam logic FLT = 1'b1;
`else
   localparam logic FLT = 1'b0;
`endif

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .pcsrc      (pcsrc),
      .pc_branch  (pc_branch),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .pc_out     (pc_out),
      .if_id_pc   (if_id_pc),
      .if_id_pc4  (if_id_pc4),
      .if_id_instr(if_id_instr),
      .if_id_valid(if_id_valid),
      .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus. Pre-edge fields are the combinational request
   // outputs seen with these inputs applied; post-edge fields are the
   // registered outputs after the rising edge.
   typedef struct {
      logic        rst, pcsrc, stall, ack;
      logic [31:0] br, rd;
      logic        chk_pre;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [31:0] exp_pc, exp_ipc, exp_ins;
      logic        exp_v, exp_flt;
   } vec_t;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   task automatic chk(input string name, input int unsigned idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
   endtask

   function automatic vec_t mk(input logic r, input logic p, input logic s,
                               input logic a, input logic [31:0] br,
                               input logic [31:0] rd, input logic cp,
                               input logic req, input logic [31:0] addr,
                               input logic [31:0] pc, input logic [31:0] ipc,
                               input logic [31:0] ins, input logic v,
                               input logic f);
      vec_t t;
      t.rst = r; t.pcsrc = p; t.stall = s; t.ack = a; t.br = br; t.rd = rd;
      t.chk_pre = cp; t.exp_req = req; t.exp_addr = addr;
      t.exp_pc = pc; t.exp_ipc = ipc; t.exp_ins = ins; t.exp_v = v;
      t.exp_flt = f;
      return t;
   endfunction

   task automatic post_check(input int unsigned idx, input logic [31:0] pc,
                             input logic [31:0] ipc, input logic [31:0] ins,
                             input logic v, input logic f);
      chk("pc_out", idx, pc_out, pc);
      chk("if_id_pc", idx, if_id_pc, ipc);
      // Reset clears pc4 to 0; otherwise it is pc+4 modulo 2^32.
      chk("if_id_pc4", idx, if_id_pc4, (ipc == 32'h0 && ins == 32'h0) ? 32'h0 : ipc + 32'd4);
      chk("if_id_instr", idx, if_id_instr, ins);
      chk("if_id_valid", idx, {31'b0, if_id_valid}, {31'b0, v});
      chk("fetch_fault", idx, {31'b0, fetch_fault}, {31'b0, f});
   endtask

   vec_t vecs[$];

   initial begin
      rst = 1'b1; pcsrc = 1'b0; pc_branch = '0; stall = 1'b0;
      imem_ack = 1'b0; imem_rdata = '0;

      //         rst pc st ack br            rd            cp req addr          pc            ipc           ins           v  flt
      // reset, ack ignored
      vecs.push_back(mk(1,0,0,1,32'h0,        32'h0,        0,0,32'h0,        32'h0,        32'h0,        32'h0,        0,0));
      vecs.push_back(mk(1,0,0,1,32'h0,        32'hDEAD,     1,0,32'h0,        32'h0,        32'h0,        32'h0,        0,0));
      // zero-latency streaming 0,4,8,12
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hA0,       1,1,32'h0,        32'h4,        32'h0,        32'hA0,       1,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hA4,       1,1,32'h4,        32'h8,        32'h4,        32'hA4,       1,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hA8,       1,1,32'h8,        32'hC,        32'h8,        32'hA8,       1,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hAC,       1,1,32'hC,        32'h10,       32'hC,        32'hAC,       1,0));
      // ack delayed 3 cycles at 0x10
      vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,1,32'h10,       32'h10,       32'hC,        32'hAC,       0,0));
      vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,1,32'h10,       32'h10,       32'hC,        32'hAC,       0,0));
      vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,1,32'h10,       32'h10,       32'hC,        32'hAC,       0,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hB0,       1,1,32'h10,       32'h14,       32'h10,       32'hB0,       1,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hB4,       1,1,32'h14,       32'h18,       32'h14,       32'hB4,       1,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hB8,       1,1,32'h18,       32'h1C,       32'h18,       32'hB8,       1,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hBC,       1,1,32'h1C,       32'h20,       32'h1C,       32'hBC,       1,0));
      // stall on ack at 0x20 for 2 cycles, then release
      vecs.push_back(mk(0,0,1,1,32'h0,        32'hC0,       1,1,32'h20,       32'h20,       32'h1C,       32'hBC,       1,0));
      vecs.push_back(mk(0,0,1,0,32'h0,        32'h0,        1,0,32'h20,       32'h20,       32'h1C,       32'hBC,       1,0));
      vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,0,32'h20,       32'h24,       32'h20,       32'hC0,       1,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hC4,       1,1,32'h24,       32'h28,       32'h24,       32'hC4,       1,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hC8,       1,1,32'h28,       32'h2C,       32'h28,       32'hC8,       1,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hCC,       1,1,32'h2C,       32'h30,       32'h2C,       32'hCC,       1,0));
      // redirect to 0x100 while request at 0x30 pending -> DRAIN
      vecs.push_back(mk(0,1,0,0,32'h100,      32'h0,        1,1,32'h30,       32'h30,       32'h2C,       32'hCC,       0,0));
      vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,1,32'h30,       32'h30,       32'h2C,       32'hCC,       0,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hD0,       1,1,32'h30,       32'h100,      32'h2C,       32'hCC,       0,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hE0,       1,1,32'h100,      32'h104,      32'h100,      32'hE0,       1,0));
      // redirect and stall together, target 0x200
      vecs.push_back(mk(0,1,1,1,32'h200,      32'hE4,       1,1,32'h104,      32'h200,      32'h100,      32'hE0,       0,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'hF0,       1,1,32'h200,      32'h204,      32'h200,      32'hF0,       1,0));
      // redirect out of HELD discards held word
      vecs.push_back(mk(0,0,1,1,32'h0,        32'hF4,       1,1,32'h204,      32'h204,      32'h200,      32'hF0,       1,0));
      vecs.push_back(mk(0,1,1,0,32'h300,      32'h0,        1,0,32'h204,      32'h300,      32'h200,      32'hF0,       0,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'h11,       1,1,32'h300,      32'h304,      32'h300,      32'h11,       1,0));
      // DRAIN: redirect overwritten, then new target arrives with the ack
      vecs.push_back(mk(0,1,0,0,32'h400,      32'h0,        1,1,32'h304,      32'h304,      32'h300,      32'h11,       0,0));
      vecs.push_back(mk(0,1,0,0,32'h500,      32'h0,        1,1,32'h304,      32'h304,      32'h300,      32'h11,       0,0));
      vecs.push_back(mk(0,1,0,1,32'h600,      32'h22,       1,1,32'h304,      32'h600,      32'h300,      32'h11,       0,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'h33,       1,1,32'h600,      32'h604,      32'h600,      32'h33,       1,0));
      // wrap at top of address space
      vecs.push_back(mk(0,1,0,1,32'hFFFFFFFC, 32'h44,       1,1,32'h604,      32'hFFFFFFFC, 32'h600,      32'h33,       0,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'h55,       1,1,32'hFFFFFFFC, 32'h0,        32'hFFFFFFFC, 32'h55,       1,0));
      // misaligned redirect 0x102 -> 0x100
      vecs.push_back(mk(0,1,0,1,32'h102,      32'h66,       1,1,32'h0,        32'h100,      32'hFFFFFFFC, 32'h55,       0,FLT));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'h77,       1,1,32'h100,      32'h104,      32'h100,      32'h77,       1,FLT));
      // reset while draining, ack in reset cycle ignored
      vecs.push_back(mk(0,1,0,0,32'h800,      32'h0,        1,1,32'h104,      32'h104,      32'h100,      32'h77,       0,FLT));
      vecs.push_back(mk(1,0,0,1,32'h0,        32'h88,       1,0,32'h104,      32'h0,        32'h0,        32'h0,        0,0));
      vecs.push_back(mk(0,0,0,1,32'h0,        32'h99,       1,1,32'h0,        32'h4,        32'h0,        32'h99,       1,0));

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; pcsrc = vecs[i].pcsrc; stall = vecs[i].stall;
         imem_ack = vecs[i].ack; pc_branch = vecs[i].br; imem_rdata = vecs[i].rd;
         #1;
         if (vecs[i].chk_pre) begin
            chk("imem_req", i, {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
            chk("imem_addr", i, imem_addr, vecs[i].exp_addr);
         end
         @(posedge clk); #1;
         post_check(i, vecs[i].exp_pc, vecs[i].exp_ipc, vecs[i].exp_ins,
                    vecs[i].exp_v, vecs[i].exp_flt);
      end

      // Stall with no ack in REQ: IF/ID frozen (valid stays 1), request held.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         rst = 1'b0; pcsrc = 1'b0; stall = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
         #1;
         chk("stall_req", 100 + c, {31'b0, imem_req}, 32'h1);
         chk("stall_addr", 100 + c, imem_addr, 32'h4);
         @(posedge clk); #1;
         post_check(100 + c, 32'h4, 32'h0, 32'h99, 1'b1, 1'b0);
      end
      @(negedge clk);
      stall = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hAA;
      @(posedge clk); #1;
      post_check(110, 32'h8, 32'h4, 32'hAA, 1'b1, 1'b0);

      // Bubble without stall leaves other IF/ID fields untouched.
      @(negedge clk);
      imem_ack = 1'b0;
      @(posedge clk); #1;
      post_check(111, 32'h8, 32'h4, 32'hAA, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 Port pcsrc  input  1  SHALL mean branch/jump taken (redirect request from EX/MEM).
REQ-005 Port pc_branch  input  32  SHALL carry the redirect target, valid when pcsrc=1.
REQ-006 Port stall  input  1  SHALL mean the hazard unit freezes PC and IF/ID.
REQ-007 Port imem_req  output  1  SHALL request an instruction-memory read.
REQ-008 Port imem_addr  output  32  SHALL carry the read address, held stable from req rise until ack.
REQ-009 Port imem_ack  input  1  SHALL mean imem_rdata is valid this cycle; latency 0..N cycles.
REQ-010 Port imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-011 Port pc_out  output  32  SHALL expose the current fetch PC register.
REQ-012 Ports if_id_pc/if_id_pc4/if_id_instr  output  32 each  SHALL carry the IF/ID register (PC, PC+4, instruction).
REQ-013 Port if_id_valid  output  1  SHALL mark the IF/ID contents as a real instruction (0 = bubble).
REQ-014 Port fetch_fault  output  1  SHALL flag a misaligned redirect (see Configuration).

Function
REQ-015 FSM states SHALL be REQ, HELD, DRAIN; imem_req=1 in REQ and DRAIN, 0 in HELD and whenever rst=1.
REQ-016 imem_addr SHALL equal pc_out in REQ and DRAIN.
REQ-017 REQ, ack=1, stall=0, pcsrc=0: IF/ID <= {pc, pc+4, rdata}, valid<=1, pc<=pc+4; stay REQ (one instruction per cycle with zero-latency memory).
REQ-018 REQ, ack=1, stall=1, pcsrc=0: rdata captured into 32-bit hold buffer, IF/ID and pc unchanged, go HELD.
REQ-019 REQ, ack=0, pcsrc=0: pc unchanged; if stall=0, if_id_valid<=0 (bubble), other IF/ID fields unchanged; if stall=1, IF/ID unchanged.
REQ-020 HELD, stall=0, pcsrc=0: IF/ID <= {pc, pc+4, hold}, valid<=1, pc<=pc+4, go REQ; stall=1 stays HELD.
REQ-021 pcsrc=1 SHALL override stall in every state and clear if_id_valid the same edge.
REQ-022 pcsrc=1 in REQ with ack=1, or in HELD: ack data/hold buffer discarded, pc<=target, go REQ.
REQ-023 pcsrc=1 in REQ with ack=0: latch target into redirect register, go DRAIN (address stays stable).
REQ-024 DRAIN: if_id_valid held 0; ack=1 discards data, pc<=redirect register, go REQ; a new pcsrc in DRAIN overwrites the redirect register (if simultaneous with ack, new target used).
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); if_id_pc4 wraps identically.
REQ-026 Redirect target low bits SHALL be forced to 2'b00 before use.

Reset
REQ-027 rst=1 SHALL set pc_out=RESET_PC, state=REQ, IF/ID fields=0, if_id_valid=0, hold and redirect registers=0, fetch_fault=0.
REQ-028 rst=1 mid-request (REQ or DRAIN) SHALL abandon the request; an ack in the reset cycle SHALL be ignored.
REQ-029 First imem_req SHALL assert in the first cycle with rst=0, address RESET_PC.

Configuration
REQ-030 Macro IF_STAGE_ALIGN_CHECK_EN defined: pcsrc=1 with pc_branch[1:0]!=0 SHALL set fetch_fault sticky high until reset; redirect still proceeds to aligned target.
REQ-031 Macro undefined: fetch_fault SHALL be constant 0; alignment per REQ-026 silently.

Verification
REQ-032 Reset, ack always 1, no stall -> pc_out 0,4,8,12 on successive cycles; if_id_valid=1 from 2nd cycle after rst falls, if_id_pc lagging pc by one.
REQ-033 Ack delayed 3 cycles at pc=0x10 -> imem_addr=0x10 stable 4 cycles, 3 bubbles (valid=0), then if_id_pc=0x10.
REQ-034 stall=1 on ack at pc=0x20 for 2 cycles -> IF/ID frozen, imem_req=0, on release if_id_instr=captured word, pc_out=0x24.
REQ-035 pcsrc=1, pc_branch=0x100 while request pending at 0x30 -> DRAIN until ack, data discarded, next request at 0x100, no valid instruction from 0x30.
REQ-036 pcsrc=1 and stall=1 same cycle, target 0x200 -> redirect wins, next imem_addr=0x200, if_id_valid=0.
REQ-037 pc_branch=0xFFFF_FFFC then ack -> pc_out 0x0000_0000 next; with IF_STAGE_ALIGN_CHECK_EN, pc_branch=0x102 -> fetch 0x100, fetch_fault=1 until rst.
